// File: rtl/utf8_decoder_if.sv
//------------------------------------------------------------------------------
// Module : utf8_decoder_if
// Brief  : Byte-stream input and decoded code-point/status output bundle.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface utf8_decoder_if;
  logic        allow;
  logic        finish;
  logic [7:0]  data;
  logic [20:0] code_point;
  logic [1:0]  status;

  modport master (output allow, finish, data, input code_point, status);
  modport slave  (input allow, finish, data, output code_point, status);
endinterface

`default_nettype wire

// File: rtl/utf8_decoder.sv
//------------------------------------------------------------------------------
// Module : utf8_decoder
// Brief  : Byte-serial UTF-8 to 21-bit Unicode scalar decoder, sticky error.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module utf8_decoder (
  input  wire            clock_i,
  input  wire            reset_i,
  utf8_decoder_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_READY   = 2'd2,
    ST_ERROR   = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    CHK_NONE = 3'd0,
    CHK_E0   = 3'd1,
    CHK_ED   = 3'd2,
    CHK_F0   = 3'd3,
    CHK_F4   = 3'd4
  } chk_t;

  state_t      state_q, state_d;
  chk_t        chk_q, chk_d;
  logic [1:0]  need_q, need_d;
  logic [20:0] acc_q, acc_d;
  logic [20:0] cp_q, cp_d;

  logic [7:0]  data;
  logic        range_bad;
  logic [20:0] acc_shift;

  assign data      = bus.data;
  assign acc_shift = {acc_q[14:0], data[5:0]};

  // Second-byte windows that exclude overlongs, surrogates and values above U+10FFFF
  always_comb begin
    range_bad = 1'b0;
    case (chk_q)
      CHK_E0:  range_bad = (data <  8'hA0);
      CHK_ED:  range_bad = (data >= 8'hA0);
      CHK_F0:  range_bad = (data <  8'h90);
      CHK_F4:  range_bad = (data >= 8'h90);
      default: range_bad = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    chk_d   = chk_q;
    need_d  = need_q;
    acc_d   = acc_q;
    cp_d    = cp_q;

    if (state_q != ST_ERROR) begin
      if (state_q == ST_READY)
        state_d = ST_IDLE;

      if (bus.allow) begin
        if (state_q != ST_PENDING) begin
          chk_d = CHK_NONE;
          if (data < 8'h80) begin
            state_d = ST_READY;
            cp_d    = {13'd0, data};
          end else if (data >= 8'hC2 && data <= 8'hDF) begin
            state_d = ST_PENDING;
            acc_d   = {16'd0, data[4:0]};
            need_d  = 2'd1;
          end else if (data >= 8'hE0 && data <= 8'hEF) begin
            state_d = ST_PENDING;
            acc_d   = {17'd0, data[3:0]};
            need_d  = 2'd2;
            if (data == 8'hE0)
              chk_d = CHK_E0;
            else if (data == 8'hED)
              chk_d = CHK_ED;
          end else if (data >= 8'hF0 && data <= 8'hF4) begin
            state_d = ST_PENDING;
            acc_d   = {18'd0, data[2:0]};
            need_d  = 2'd3;
            if (data == 8'hF0)
              chk_d = CHK_F0;
            else if (data == 8'hF4)
              chk_d = CHK_F4;
          end else begin
            state_d = ST_ERROR;
          end
        end else if (data[7:6] != 2'b10 || range_bad) begin
          state_d = ST_ERROR;
        end else begin
          acc_d  = acc_shift;
          need_d = need_q - 2'd1;
          chk_d  = CHK_NONE;
          if (need_q == 2'd1) begin
            state_d = ST_READY;
            cp_d    = acc_shift;
          end else begin
            state_d = ST_PENDING;
          end
        end
      end

      // End of stream while a sequence is still open means truncation
      if (bus.finish && state_d == ST_PENDING)
        state_d = ST_ERROR;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      chk_q   <= CHK_NONE;
      need_q  <= 2'd0;
      acc_q   <= 21'd0;
      cp_q    <= 21'd0;
    end else begin
      state_q <= state_d;
      chk_q   <= chk_d;
      need_q  <= need_d;
      acc_q   <= acc_d;
      cp_q    <= cp_d;
    end
  end

  assign bus.status     = state_q;
  assign bus.code_point = cp_q;

endmodule

`default_nettype wire

// File: tb/tb_utf8_decoder.sv
//------------------------------------------------------------------------------
// Module : tb_utf8_decoder
// Brief  : Directed self-checking bench for utf8_decoder.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_utf8_decoder;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PEND = 2'd1;
  localparam logic [1:0] S_RDY  = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  utf8_decoder_if bus ();

  utf8_decoder dut (
    .clock_i (clk),
    .reset_i (rst_n),
    .bus     (bus.slave)
  );

  task automatic step(input logic a, input logic f, input logic [7:0] d);
    bus.allow  = a;
    bus.finish = f;
    bus.data   = d;
    @(posedge clk);
    #1;
    bus.allow  = 1'b0;
    bus.finish = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(1'b1, 1'b1, 8'hC0);
    step(1'b1, 1'b0, 8'h41);
    checks++;
    if (bus.status !== S_IDLE || bus.code_point !== 21'h0) begin
      errors++;
      $display("FAIL reset_hold: status=%0d cp=%06h want status=0 cp=000000", bus.status, bus.code_point);
    end
    rst_n = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    checks++;
    if (bus.status !== S_IDLE || bus.code_point !== 21'h0) begin
      errors++;
      $display("FAIL reset_release: status=%0d cp=%06h want status=0 cp=000000", bus.status, bus.code_point);
    end
  endtask

  task automatic test_ascii();
    step(1'b1, 1'b0, 8'h48);
    checks++;
    if (bus.status !== S_RDY || bus.code_point !== 21'h48) begin
      errors++;
      $display("FAIL ascii_ready: status=%0d cp=%06h want status=2 cp=000048", bus.status, bus.code_point);
    end
    step(1'b0, 1'b0, 8'h00);
    checks++;
    if (bus.status !== S_IDLE || bus.code_point !== 21'h48) begin
      errors++;
      $display("FAIL ascii_idle: status=%0d cp=%06h want status=0 cp=000048", bus.status, bus.code_point);
    end
  endtask

  task automatic test_two_byte();
    step(1'b1, 1'b0, 8'hD0);
    checks++;
    if (bus.status !== S_PEND || bus.code_point !== 21'h48) begin
      errors++;
      $display("FAIL two_pending: status=%0d cp=%06h want status=1 cp=000048", bus.status, bus.code_point);
    end
    step(1'b0, 1'b0, 8'hFF);
    checks++;
    if (bus.status !== S_PEND) begin
      errors++;
      $display("FAIL two_hold: status=%0d want 1", bus.status);
    end
    step(1'b1, 1'b0, 8'h9C);
    checks++;
    if (bus.status !== S_RDY || bus.code_point !== 21'h41C) begin
      errors++;
      $display("FAIL two_ready: status=%0d cp=%06h want status=2 cp=00041C", bus.status, bus.code_point);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  bytes [18] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20, 8'hD0, 8'h9C,
                                8'hD0, 8'hB8, 8'hD1, 8'h80, 8'h20, 8'hF0, 8'h9F, 8'h91, 8'h8B};
    logic [20:0] exp_cp [12] = '{21'h48, 21'h65, 21'h6C, 21'h6C, 21'h6F, 21'h2C, 21'h20,
                                 21'h41C, 21'h438, 21'h440, 21'h20, 21'h1F44B};
    int n_ready = 0;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      step(1'b1, 1'b0, bytes[i]);
      if (bus.status === S_RDY) begin
        if (n_ready < 12) begin
          checks++;
          if (bus.code_point !== exp_cp[n_ready]) begin
            errors++;
            $display("FAIL stream_cp[%0d]: got %06h want %06h", n_ready, bus.code_point, exp_cp[n_ready]);
          end
        end
        n_ready++;
      end
    end
    step(1'b0, 1'b0, 8'h00);
    checks++;
    if (n_ready != 12 || bus.status !== S_IDLE) begin
      errors++;
      $display("FAIL stream_count: ready=%0d status=%0d want ready=12 status=0", n_ready, bus.status);
    end
  endtask

  task automatic test_boundaries();
    logic [7:0]  seq [4][4] = '{'{8'hE0, 8'hA0, 8'h80, 8'h00},
                                '{8'hED, 8'h9F, 8'hBF, 8'h00},
                                '{8'hF0, 8'h90, 8'h80, 8'h80},
                                '{8'hF4, 8'h8F, 8'hBF, 8'hBF}};
    int          len [4]    = '{3, 3, 4, 4};
    logic [20:0] exp_cp [4] = '{21'h000800, 21'h00D7FF, 21'h010000, 21'h10FFFF};
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < len[t]; k++)
        step(1'b1, 1'b0, seq[t][k]);
      checks++;
      if (bus.status !== S_RDY || bus.code_point !== exp_cp[t]) begin
        errors++;
        $display("FAIL boundary[%0d]: status=%0d cp=%06h want status=2 cp=%06h", t, bus.status, bus.code_point, exp_cp[t]);
      end
    end
  endtask

  task automatic test_errors();
    logic [7:0] seq [6][2] = '{'{8'hC0, 8'h00}, '{8'h80, 8'h00}, '{8'hE0, 8'h80},
                               '{8'hED, 8'hA0}, '{8'hF4, 8'h90}, '{8'hD0, 8'h41}};
    int         len [6]    = '{1, 1, 2, 2, 2, 2};
    for (int t = 0; t < 6; t++) begin
      do_reset();
      for (int k = 0; k < len[t]; k++)
        step(1'b1, 1'b0, seq[t][k]);
      checks++;
      if (bus.status !== S_ERR) begin
        errors++;
        $display("FAIL err_detect[%0d]: status=%0d want 3", t, bus.status);
      end
      step(1'b1, 1'b0, 8'h41);
      step(1'b0, 1'b0, 8'h00);
      checks++;
      if (bus.status !== S_ERR || bus.code_point !== 21'h0) begin
        errors++;
        $display("FAIL err_sticky[%0d]: status=%0d cp=%06h want status=3 cp=000000", t, bus.status, bus.code_point);
      end
    end
    do_reset();
    checks++;
    if (bus.status !== S_IDLE) begin
      errors++;
      $display("FAIL err_clear: status=%0d want 0", bus.status);
    end
  endtask

  task automatic test_finish();
    do_reset();
    step(1'b1, 1'b0, 8'hE2);
    step(1'b1, 1'b0, 8'h82);
    step(1'b0, 1'b1, 8'h00);
    checks++;
    if (bus.status !== S_ERR) begin
      errors++;
      $display("FAIL finish_trunc: status=%0d want 3", bus.status);
    end
    do_reset();
    step(1'b1, 1'b0, 8'hE2);
    step(1'b1, 1'b0, 8'h82);
    step(1'b1, 1'b0, 8'hAC);
    checks++;
    if (bus.status !== S_RDY || bus.code_point !== 21'h20AC) begin
      errors++;
      $display("FAIL euro_ready: status=%0d cp=%06h want status=2 cp=0020AC", bus.status, bus.code_point);
    end
    step(1'b0, 1'b1, 8'h00);
    checks++;
    if (bus.status !== S_IDLE || bus.code_point !== 21'h20AC) begin
      errors++;
      $display("FAIL finish_after_ready: status=%0d cp=%06h want status=0 cp=0020AC", bus.status, bus.code_point);
    end
    step(1'b1, 1'b0, 8'hC3);
    step(1'b1, 1'b1, 8'hA9);
    checks++;
    if (bus.status !== S_RDY || bus.code_point !== 21'hE9) begin
      errors++;
      $display("FAIL finish_same_cycle: status=%0d cp=%06h want status=2 cp=0000E9", bus.status, bus.code_point);
    end
    step(1'b1, 1'b1, 8'hE2);
    checks++;
    if (bus.status !== S_ERR) begin
      errors++;
      $display("FAIL finish_lead: status=%0d want 3", bus.status);
    end
  endtask

  initial begin
    bus.allow  = 1'b0;
    bus.finish = 1'b0;
    bus.data   = 8'h00;
    test_reset();
    test_ascii();
    test_two_byte();
    test_back_to_back();
    test_boundaries();
    test_errors();
    test_finish();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
